// File: rtl/pio_regs_pkg.sv
// Shared register offsets and reset defaults for the edge-capture input PIO.
package pio_regs_pkg;
  localparam int BUS_W = 32;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_RAW       = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_EDGE_RISE = 3'd4;
  localparam logic [2:0] ADDR_EDGE_FALL = 3'd5;
  localparam logic [2:0] ADDR_DEBOUNCE  = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  localparam logic RISE_DEF = 1'b0;
  localparam logic FALL_DEF = 1'b1;
  localparam int   DEB_DEF  = 0;
endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, mismatch-count debouncer and edge pulses.
// Stable level follows the synchronised level after limit+1 consecutive mismatch cycles.
module pio_debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_raw,
  output logic             o_stable,
  output logic             o_rise,
  output logic             o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_stable_d;
  logic                   w_raw;

  assign w_raw = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_stable_d <= r_stable;
      if (w_raw == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_limit) begin
        // >= so a limit lowered below the running count commits at once
        r_stable <= w_raw;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_raw    = w_raw;
  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_d;
  assign o_fall   = ~r_stable & r_stable_d;
endmodule

// File: rtl/nios_system_edge_capture_pio.sv
// Avalon-MM input PIO: debounced inputs, per-bit rise/fall capture with W1C clear, masked level irq.
// Read data is registered (1-cycle latency); the slave never stalls.
module nios_system_edge_capture_pio
  import pio_regs_pkg::*;
#(
  parameter int   DATA_WIDTH   = 18,
  parameter int   SYNC_STAGES  = 2,
  parameter int   CNT_W        = 16,
  parameter logic RISE_DEFAULT = RISE_DEF,
  parameter logic FALL_DEFAULT = FALL_DEF,
  parameter int   DEB_DEFAULT  = DEB_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [BUS_W-1:0]      writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [BUS_W-1:0]      readdata,
  output logic                  irq
);
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_capture;
  logic [DATA_WIDTH-1:0] r_edge_rise;
  logic [DATA_WIDTH-1:0] r_edge_fall;
  logic [CNT_W-1:0]      r_deb_limit;
  logic [BUS_W-1:0]      r_readdata;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_stable;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_detect;
  logic [DATA_WIDTH-1:0] w_clear;
  logic [BUS_W-1:0]      w_rdmux;
  logic                  w_wr;
  logic                  w_unused_wd;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .i_in    (in_port[g]),
      .i_limit (r_deb_limit),
      .o_raw   (w_raw[g]),
      .o_stable(w_stable[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign w_wr        = chipselect & ~write_n;
  assign w_detect    = (w_rise & r_edge_rise) | (w_fall & r_edge_fall);
  assign w_clear     = (w_wr && address == ADDR_EDGE_CAP) ? writedata[DATA_WIDTH-1:0] : '0;
  assign w_unused_wd = ^writedata;

  always_comb begin
    w_rdmux = '0;
    case (address)
      ADDR_DATA:      w_rdmux[DATA_WIDTH-1:0] = w_stable;
      ADDR_RAW:       w_rdmux[DATA_WIDTH-1:0] = w_raw;
      ADDR_IRQ_MASK:  w_rdmux[DATA_WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAP:  w_rdmux[DATA_WIDTH-1:0] = r_capture;
      ADDR_EDGE_RISE: w_rdmux[DATA_WIDTH-1:0] = r_edge_rise;
      ADDR_EDGE_FALL: w_rdmux[DATA_WIDTH-1:0] = r_edge_fall;
      ADDR_DEBOUNCE:  w_rdmux[CNT_W-1:0]      = r_deb_limit;
      ADDR_RSVD:      w_rdmux                 = '0;
      default:        w_rdmux                 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask  <= '0;
      r_capture   <= '0;
      r_edge_rise <= {DATA_WIDTH{RISE_DEFAULT}};
      r_edge_fall <= {DATA_WIDTH{FALL_DEFAULT}};
      r_deb_limit <= CNT_W'(DEB_DEFAULT);
      r_readdata  <= '0;
      r_irq       <= 1'b0;
    end else begin
      // a detect wins over a same-cycle clear so no edge is lost
      r_capture  <= w_detect | (r_capture & ~w_clear);
      r_irq      <= |(r_capture & r_irq_mask);
      r_readdata <= w_rdmux;
      if (w_wr) begin
        case (address)
          ADDR_IRQ_MASK:  r_irq_mask  <= writedata[DATA_WIDTH-1:0];
          ADDR_EDGE_RISE: r_edge_rise <= writedata[DATA_WIDTH-1:0];
          ADDR_EDGE_FALL: r_edge_fall <= writedata[DATA_WIDTH-1:0];
          ADDR_DEBOUNCE:  r_deb_limit <= writedata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;
endmodule

// File: tb/tb_nios_system_edge_capture_pio.sv
// Scoreboard bench: stimulus pushes expectations from a cycle reference model, a monitor pops and compares.
module tb_nios_system_edge_capture_pio;
  localparam int DW = 18;
  localparam int SS = 2;
  localparam int CW = 16;
  localparam int RW = CW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [2:0]    address = 3'd0;
  logic [31:0]   writedata = 32'd0;
  logic [DW-1:0] in_port = '0;
  logic [31:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  nios_system_edge_capture_pio dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  // Reference state: input history, debounced level, its previous value, run of mismatches per bit.
  typedef struct packed {
    logic [SS-1:0][DW-1:0] pipe;
    logic [DW-1:0]         stable;
    logic [DW-1:0]         prev;
    logic [DW-1:0]         mask;
    logic [DW-1:0]         cap;
    logic [DW-1:0]         rise;
    logic [DW-1:0]         fall;
    logic [CW-1:0]         lim;
    logic [DW-1:0][RW-1:0] run;
  } model_t;

  typedef struct {
    string       name;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        chk_const;
    logic [31:0] exp_const;
  } chk_t;

  model_t        m;
  chk_t          q[$];
  chk_t          mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] cur_in = '0;

  function automatic model_t mstep(model_t s, logic rst, logic cs, logic wn, logic [2:0] a,
                                   logic [31:0] wd, logic [DW-1:0] inp);
    model_t        n;
    logic          wr;
    logic [DW-1:0] det;
    logic [DW-1:0] clr;
    logic [DW-1:0] raw;
    int            r;
    n = s;
    if (rst) begin
      n      = '0;
      n.fall = '1;
      return n;
    end
    wr    = cs & ~wn;
    det   = (s.stable & ~s.prev & s.rise) | (~s.stable & s.prev & s.fall);
    clr   = (wr && a == 3'd3) ? wd[DW-1:0] : '0;
    n.cap = det | (s.cap & ~clr);
    if (wr) begin
      if (a == 3'd2) n.mask = wd[DW-1:0];
      if (a == 3'd4) n.rise = wd[DW-1:0];
      if (a == 3'd5) n.fall = wd[DW-1:0];
      if (a == 3'd6) n.lim  = wd[CW-1:0];
    end
    n.prev = s.stable;
    raw    = s.pipe[SS-1];
    n.pipe = {s.pipe[SS-2:0], inp};
    for (int i = 0; i < DW; i++) begin
      if (raw[i] != s.stable[i]) begin
        r = int'(s.run[i]) + 1;
        if (r > int'(s.lim)) begin
          n.stable[i] = raw[i];
          n.run[i]    = '0;
        end else begin
          n.run[i] = RW'(r);
        end
      end else begin
        n.run[i] = '0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] mread(model_t s, logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v[DW-1:0] = s.stable;
      3'd1: v[DW-1:0] = s.pipe[SS-1];
      3'd2: v[DW-1:0] = s.mask;
      3'd3: v[DW-1:0] = s.cap;
      3'd4: v[DW-1:0] = s.rise;
      3'd5: v[DW-1:0] = s.fall;
      3'd6: v[CW-1:0] = s.lim;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) m <= mstep(m, reset, chipselect, write_n, address, writedata, in_port);

  task automatic step(input string nm, input logic rst, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic cc, input logic [31:0] cexp);
    chk_t e;
    @(negedge clk);
    reset   = rst;
    address = a;
    writedata = wd;
    in_port = cur_in;
    if (rst) begin
      chipselect = 1'b0;
      write_n    = 1'b1;
    end else if (wr) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
    end else begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
    end
    e.name      = nm;
    e.exp_rd    = rst ? 32'd0 : mread(m, a);
    e.exp_irq   = rst ? 1'b0 : |(m.cap & m.mask);
    e.chk_const = cc;
    e.exp_const = cexp;
    q.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [2:0] a);
    step(nm, 1'b0, 1'b0, a, $urandom, 1'b0, 32'd0);
  endtask

  task automatic rdc(input string nm, input logic [2:0] a, input logic [31:0] v);
    step(nm, 1'b0, 1'b0, a, $urandom, 1'b1, v);
  endtask

  task automatic wr(input string nm, input logic [2:0] a, input logic [31:0] d);
    step(nm, 1'b0, 1'b1, a, d, 1'b0, 32'd0);
  endtask

  always @(posedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      #1;
      n_cmp++;
      if (readdata !== mon_e.exp_rd) begin
        n_bad++;
        $display("FAIL %s readdata got %h expected %h", mon_e.name, readdata, mon_e.exp_rd);
      end
      n_cmp++;
      if (irq !== mon_e.exp_irq) begin
        n_bad++;
        $display("FAIL %s irq got %b expected %b", mon_e.name, irq, mon_e.exp_irq);
      end
      if (mon_e.chk_const) begin
        n_cmp++;
        if (readdata !== mon_e.exp_const) begin
          n_bad++;
          $display("FAIL %s readdata got %h required %h", mon_e.name, readdata, mon_e.exp_const);
        end
      end
    end
  end

  initial begin
    logic [31:0] t1 [0:6];
    logic [2:0]  a;
    logic [31:0] d;
    t1 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0003FFFF, 32'd0};

    repeat (3) step("reset", 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 7; i++) rdc("t1_reset_value", 3'(i), t1[i]);

    // falling edge on bit 3 with no debounce
    wr("t2_cfg", 3'd5, 32'h8);
    wr("t2_cfg", 3'd2, 32'h8);
    wr("t2_cfg", 3'd6, 32'h0);
    cur_in[3] = 1'b1;
    repeat (8) rd("t2_high", 3'd3);
    cur_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3)      rdc("t2_cap_not_yet", 3'd3, 32'h0);
      else if (k == 4) rdc("t2_cap_set", 3'd3, 32'h8);
      else             rd("t2_fall", 3'd3);
    end
    wr("t2_w1c", 3'd3, 32'h8);
    rdc("t2_cap_cleared", 3'd3, 32'h0);
    repeat (3) rd("t2_after_clear", 3'd3);

    // debounce limit 5: short glitch is rejected, long hold is accepted
    wr("t3_cfg", 3'd6, 32'd5);
    cur_in[0] = 1'b1;
    repeat (4) rd("t3_glitch", 3'd0);
    cur_in[0] = 1'b0;
    for (int k = 0; k < 12; k++) rd("t3_settle", 3'(k % 2));
    rdc("t3_no_data_change", 3'd0, 32'h0);
    rdc("t3_no_capture", 3'd3, 32'h0);
    cur_in[0] = 1'b1;
    for (int k = 0; k < 12; k++) rd("t3_hold", 3'(k % 2));
    rdc("t3_data_set", 3'd0, 32'h1);
    cur_in[0] = 1'b0;
    for (int k = 0; k < 12; k++) rd("t3_release", 3'(k % 2));

    // both edges on bit 0, then a clear colliding with a detect
    wr("t4_cfg", 3'd6, 32'd0);
    wr("t4_cfg", 3'd4, 32'h1);
    wr("t4_cfg", 3'd5, 32'h1);
    wr("t4_clr_all", 3'd3, 32'h3FFFF);
    rdc("t4_clean", 3'd3, 32'h0);
    cur_in[0] = 1'b1;
    repeat (7) rd("t4_rise", 3'd3);
    rdc("t4_rise_captured", 3'd3, 32'h1);
    wr("t4_w1c", 3'd3, 32'h1);
    rdc("t4_rise_cleared", 3'd3, 32'h0);
    cur_in[0] = 1'b0;
    for (int k = 0; k < 3; k++) rd("t4_fall", 3'd3);
    wr("t4_w1c_vs_detect", 3'd3, 32'h1);
    rdc("t4_bit_kept", 3'd3, 32'h1);

    // width masking and read-only offsets
    wr("t5_mask", 3'd2, 32'hFFFFFFFF);
    rdc("t5_mask_width", 3'd2, 32'h0003FFFF);
    wr("t5_data_wr", 3'd0, 32'hFFFFFFFF);
    rdc("t5_data_ro", 3'd0, 32'h0);
    wr("t5_rsvd_wr", 3'd7, 32'hFFFFFFFF);
    rdc("t5_rsvd", 3'd7, 32'h0);
    wr("t5_deb_width", 3'd6, 32'hFFFF0003);
    rdc("t5_deb_rd", 3'd6, 32'h3);
    repeat (3) rd("t5_irq", 3'd3);

    // reset in the middle of a debounce count
    wr("t6_cfg", 3'd6, 32'd10);
    cur_in[5] = 1'b1;
    repeat (5) rd("t6_count", 3'd0);
    step("t6_reset", 1'b1, 1'b0, 3'd3, 32'd0, 1'b0, 32'd0);
    rdc("t6_cap_cleared", 3'd3, 32'h0);
    repeat (10) rd("t6_after", 3'd3);
    rdc("t6_no_spurious", 3'd3, 32'h0);
    rdc("t6_data_level", 3'd0, 32'h20);

    // randomised traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) cur_in = cur_in ^ DW'(1 << $urandom_range(0, DW - 1));
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd6) d = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) step("rnd_reset", 1'b1, 1'b0, a, d, 1'b0, 32'd0);
      else if ($urandom_range(0, 3) == 0) wr("rnd_wr", a, d);
      else rd("rnd_rd", a);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
